quant_divide_pipe: RTL and testbench
====================================

# quant_divide_pipe

Parametrised, fully pipelined signed-by-unsigned integer divider for the JPEG quantiser: divides a signed DCT coefficient by an unsigned quantisation-table entry, one result per cycle. Compared with the fixed-width divider it adds:
- generic widths and register spacing;
- selectable round-to-nearest;
- divide-by-zero and overflow saturation with flags;
- a pass-through tag;
- a valid/ready handshake with global stall.

It sits between the DCT output buffer and the zig-zag/entropy stage.

## Interface
- DW, 19: dividend width, two's complement signed.
- VW, 8: divisor width, unsigned.
- QW, 11: quotient width, signed; also the number of restoring iterations.
- REG_EVERY, 2: pipeline register inserted after every REG_EVERY iteration steps; legal values 1..QW.
- ROUND, 1: 0 = truncate toward zero; 1 = round half away from zero.
- TW, 6: sideband tag width (coefficient index).
- clk  in  1  single clock, rising edge.
- rst  in  1  asynchronous reset, active-high.
- in_valid  in  1  dividend/divisor/tag valid.
- in_ready  out  1  block accepts input this cycle.
- dividend  in  DW  signed dividend.
- divisor  in  VW  unsigned divisor.
- in_tag  in  TW  sideband, returned unchanged with the result.
- out_valid  out  1  result valid.
- out_ready  in  1  downstream accepts result.
- quotient  out  QW  signed result.
- out_tag  out  TW  tag of this result.
- out_dz  out  1  divisor was zero.
- out_sat  out  1  result saturated (overflow or dz).

## Operation
- **Stage 0 (input register)**
  - Capture sign s = dividend[DW-1], |dividend| as DW-bit unsigned (-2^(DW-1) maps to 2^(DW-1)), divisor, tag.
  - Capture dz = (divisor==0).
  - Capture ov = (|dividend| >= divisor·2^QW), computed at DW+1 bits.
- **Iteration steps k = 1..QW**
  - Restoring step on partial remainder R: trial T = R - (divisor << (QW-k)).
  - If T ≥ 0: quotient bit = 1 and R = T; else quotient bit = 0 and R is kept.
  - Quotient bits are assembled MSB first.
  - A register follows step k when k mod REG_EVERY == 0 and k < QW.
  - Each register carries R, divisor, partial quotient, s, dz, ov, tag and valid.
- **Output register (final stage)**
  - q = magnitude; r = final remainder.
  - If ROUND=1 and 2r ≥ divisor, then m = q+1 (computed at QW+1 bits); else m = q.
  - dz=1: quotient = s ? -2^(QW-1) : 2^(QW-1)-1; out_dz=1; out_sat=1.
  - Otherwise, if ov, or s=0 and m > 2^(QW-1)-1, or s=1 and m > 2^(QW-1): saturate to the same limits with out_sat=1.
  - Otherwise quotient = s ? -m : m; out_sat=0.
  - A zero magnitude yields quotient 0 regardless of sign.
- **Handshake**
  - advance = ~out_valid | out_ready; in_ready = advance (combinational).
  - All pipeline registers, including valid bits, load only when advance=1; otherwise the whole pipe holds.
  - Transfer in: in_valid & in_ready. Transfer out: out_valid & out_ready.
  - Bubbles are not collapsed.
  - Results leave in input order; none are dropped or duplicated.
  - quotient, out_tag and flags stay stable while out_valid=1 and out_ready=0.
- Data registers load only when the upstream valid is 1 and advance=1, to save power. Valid registers load on every advance.

## Timing
- Register count LAT = 2 + floor((QW-1)/REG_EVERY). Defaults give LAT = 7.
- Latency: an input accepted at edge n appears on out_valid after edge n+LAT-1 when out_ready is held 1. LAT register stages lie between input and output.
- Throughput: one result per cycle while out_ready=1. Each cycle with out_valid=1 and out_ready=0 adds one cycle to every in-flight item.
- Reset, at assertion (asynchronous): all valid bits 0, out_valid=0, quotient=0, out_tag=0, out_dz=0, out_sat=0, in_ready=1 (once out_valid=0).
- Reset mid-operation discards every in-flight item. No output appears after release until a new input has traversed LAT stages.
- Simultaneous in-transfer and out-transfer in the same cycle is legal and sustains full rate.

## Test plan
- **Rounding** (defaults): 1000/16.
  - ROUND=1 → 63; -1000/16 → -63; 999/16 → 62.
  - ROUND=0: 1000/16 → 62 and -1000/16 → -62.
  - All with out_sat=0 and out_dz=0.
- **Divide by zero:** 500/0 → 1023, out_dz=1, out_sat=1. -5/0 → -1024, same flags. 0/0 → 1023.
- **Saturation and limits:**
  - 262143/1 → 1023, sat=1; -262144/1 → -1024, sat=1.
  - -1024/1 → -1024, sat=0; 1024/1 → 1023, sat=1.
  - ROUND=1: 2047/2 → 1023 (exact 1023.5 rounds to 1024, saturates), sat=1.
- **Latency and throughput:**
  - 32 back-to-back random inputs with out_ready=1: first out_valid exactly LAT cycles after first accept, then 32 consecutive valid cycles.
  - Tags 0..31 return in order; every result matches the reference model.
- **Backpressure:**
  - Same stream with out_ready pattern 1,0,0,1 repeating.
  - in_ready deasserts whenever out_valid=1 and out_ready=0.
  - Outputs hold stable while stalled; no loss or duplication; order preserved.
- **Reset mid-stream:** assert rst for 1 cycle after 3 accepts.
  - All outputs go to 0 immediately; none of the 3 results ever appear.
  - The next input, 100/10, returns 10 after LAT cycles.
- **Parameter sweep:** repeat the latency and saturation checks with REG_EVERY=1 and QW=8 (LAT=9), and with REG_EVERY=QW (LAT=2).

Source files
------------

// File: rtl/quant_divide_pipe.sv
// Pipelined signed-by-unsigned restoring divider for the JPEG quantiser.
// Saturating, optionally rounding, valid/ready with a global stall.
module quant_divide_pipe #(
    parameter int DW        = 19,
    parameter int VW        = 8,
    parameter int QW        = 11,
    parameter int REG_EVERY = 2,
    parameter int ROUND     = 1,
    parameter int TW        = 6
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [DW-1:0] dividend,
    input  logic [VW-1:0] divisor,
    input  logic [TW-1:0] in_tag,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [QW-1:0] quotient,
    output logic [TW-1:0] out_tag,
    output logic          out_dz,
    output logic          out_sat
);
    localparam int NR = (QW - 1) / REG_EVERY;
    localparam int WW = ((DW > VW + QW) ? DW : VW + QW) + 1;
    localparam logic [QW:0] MPOS = (QW + 1)'((1 << (QW - 1)) - 1);
    localparam logic [QW:0] MNEG = (QW + 1)'(1 << (QW - 1));
    localparam logic [QW-1:0] QPOS = {1'b0, {(QW - 1){1'b1}}};
    localparam logic [QW-1:0] QNEG = {1'b1, {(QW - 1){1'b0}}};

    logic advance;
    assign advance  = ~out_valid | out_ready;
    assign in_ready = advance;

    logic [DW-1:0] mag_d;
    logic          ov_d;
    assign mag_d = dividend[DW-1] ? -dividend : dividend;
    assign ov_d  = WW'(mag_d) >= (WW'(divisor) << QW);

    // Index 0 is the input register, 1..NR the inter-step registers.
    logic [DW-1:0] p_rem_q [NR+1];
    logic [QW-1:0] p_quo_q [NR+1];
    logic [VW-1:0] p_div_q [NR+1];
    logic [TW-1:0] p_tag_q [NR+1];
    logic          p_s_q   [NR+1];
    logic          p_dz_q  [NR+1];
    logic          p_ov_q  [NR+1];
    logic          p_vld_q [NR+1];

    logic [DW-1:0] n_rem_d [NR+1];
    logic [QW-1:0] n_quo_d [NR+1];

    function automatic logic [DW+QW-1:0] steps(
        input logic [DW-1:0] rem,
        input logic [QW-1:0] quo,
        input logic [VW-1:0] dv,
        input int            k0,
        input int            k1
    );
        logic [DW-1:0] r;
        logic [QW-1:0] q;
        logic [WW-1:0] t;
        r = rem;
        q = quo;
        for (int k = 1; k <= QW; k++) begin
            if (k >= k0 && k <= k1) begin
                t = WW'(dv) << (QW - k);
                if (WW'(r) >= t) begin
                    r = r - t[DW-1:0];
                    q[QW-k] = 1'b1;
                end
            end
        end
        return {r, q};
    endfunction

    for (genvar j = 0; j <= NR; j++) begin : g_seg
        localparam int K0 = j * REG_EVERY + 1;
        localparam int K1 = ((j + 1) * REG_EVERY < QW) ? (j + 1) * REG_EVERY : QW;
        assign {n_rem_d[j], n_quo_d[j]} =
            steps(p_rem_q[j], p_quo_q[j], p_div_q[j], K0, K1);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int j = 0; j <= NR; j++) begin
                p_vld_q[j] <= 1'b0;
                p_rem_q[j] <= '0;
                p_quo_q[j] <= '0;
                p_div_q[j] <= '0;
                p_tag_q[j] <= '0;
                p_s_q[j]   <= 1'b0;
                p_dz_q[j]  <= 1'b0;
                p_ov_q[j]  <= 1'b0;
            end
        end else if (advance) begin
            p_vld_q[0] <= in_valid;
            if (in_valid) begin
                p_rem_q[0] <= mag_d;
                p_quo_q[0] <= '0;
                p_div_q[0] <= divisor;
                p_tag_q[0] <= in_tag;
                p_s_q[0]   <= dividend[DW-1];
                p_dz_q[0]  <= (divisor == '0);
                p_ov_q[0]  <= ov_d;
            end
            for (int j = 1; j <= NR; j++) begin
                p_vld_q[j] <= p_vld_q[j-1];
                if (p_vld_q[j-1]) begin
                    p_rem_q[j] <= n_rem_d[j-1];
                    p_quo_q[j] <= n_quo_d[j-1];
                    p_div_q[j] <= p_div_q[j-1];
                    p_tag_q[j] <= p_tag_q[j-1];
                    p_s_q[j]   <= p_s_q[j-1];
                    p_dz_q[j]  <= p_dz_q[j-1];
                    p_ov_q[j]  <= p_ov_q[j-1];
                end
            end
        end
    end

    logic          rnd_d;
    logic [QW:0]   m_d;
    logic [QW-1:0] q_d;
    logic          sat_d;

    // Half away from zero on the magnitude: bump when 2r >= divisor.
    assign rnd_d = (ROUND != 0) &&
                   (WW'({n_rem_d[NR], 1'b0}) >= WW'(p_div_q[NR]));
    assign m_d   = {1'b0, n_quo_d[NR]} + {{QW{1'b0}}, rnd_d};

    always_comb begin
        q_d   = '0;
        sat_d = 1'b0;
        if (p_dz_q[NR] || p_ov_q[NR] ||
            (!p_s_q[NR] && m_d > MPOS) || (p_s_q[NR] && m_d > MNEG)) begin
            q_d   = p_s_q[NR] ? QNEG : QPOS;
            sat_d = 1'b1;
        end else begin
            q_d = p_s_q[NR] ? -m_d[QW-1:0] : m_d[QW-1:0];
        end
    end

    logic          vld_q;
    logic [QW-1:0] quo_q;
    logic [TW-1:0] tag_q;
    logic          dz_q;
    logic          sat_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld_q <= 1'b0;
            quo_q <= '0;
            tag_q <= '0;
            dz_q  <= 1'b0;
            sat_q <= 1'b0;
        end else if (advance) begin
            vld_q <= p_vld_q[NR];
            if (p_vld_q[NR]) begin
                quo_q <= q_d;
                tag_q <= p_tag_q[NR];
                dz_q  <= p_dz_q[NR];
                sat_q <= sat_d;
            end
        end
    end

    assign out_valid = vld_q;
    assign quotient  = quo_q;
    assign out_tag   = tag_q;
    assign out_dz    = dz_q;
    assign out_sat   = sat_q;
endmodule

// File: tb/tb_quant_divide_pipe.sv
// Bench for quant_divide_pipe: directed table, random streams against an
// arithmetic reference, backpressure, mid-stream reset, parameter variants.
module tb_quant_divide_pipe;
    typedef struct {
        int inst;
        int a;
        int b;
        int q;
        bit dz;
        bit sat;
    } vec_t;

    typedef struct {
        int q;
        bit dz;
        bit sat;
        int tag;
    } exp_t;

    localparam int NV = 24;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [3:0]  iv = '0;
    logic [18:0] dvd = '0;
    logic [7:0]  dvs = '0;
    logic [5:0]  tg = '0;
    logic        ordy = 1'b1;
    logic [3:0]  irdy, ovld, odz, osat;
    logic [5:0]  otag [4];
    logic [10:0] q0, q1, q3;
    logic [7:0]  q2;

    int qws  [4] = '{11, 11, 8, 11};
    int rnds [4] = '{1, 0, 1, 1};
    int lats [4] = '{7, 7, 9, 2};

    int n_chk = 0;
    int n_fail = 0;
    vec_t vt [NV];

    always #5 clk = ~clk;

    quant_divide_pipe u_r1 (
        .clk(clk), .rst(rst), .in_valid(iv[0]), .in_ready(irdy[0]),
        .dividend(dvd), .divisor(dvs), .in_tag(tg),
        .out_valid(ovld[0]), .out_ready(ordy), .quotient(q0),
        .out_tag(otag[0]), .out_dz(odz[0]), .out_sat(osat[0])
    );
    quant_divide_pipe #(.ROUND(0)) u_r0 (
        .clk(clk), .rst(rst), .in_valid(iv[1]), .in_ready(irdy[1]),
        .dividend(dvd), .divisor(dvs), .in_tag(tg),
        .out_valid(ovld[1]), .out_ready(ordy), .quotient(q1),
        .out_tag(otag[1]), .out_dz(odz[1]), .out_sat(osat[1])
    );
    quant_divide_pipe #(.QW(8), .REG_EVERY(1)) u_q8 (
        .clk(clk), .rst(rst), .in_valid(iv[2]), .in_ready(irdy[2]),
        .dividend(dvd), .divisor(dvs), .in_tag(tg),
        .out_valid(ovld[2]), .out_ready(ordy), .quotient(q2),
        .out_tag(otag[2]), .out_dz(odz[2]), .out_sat(osat[2])
    );
    quant_divide_pipe #(.REG_EVERY(11)) u_rq (
        .clk(clk), .rst(rst), .in_valid(iv[3]), .in_ready(irdy[3]),
        .dividend(dvd), .divisor(dvs), .in_tag(tg),
        .out_valid(ovld[3]), .out_ready(ordy), .quotient(q3),
        .out_tag(otag[3]), .out_dz(odz[3]), .out_sat(osat[3])
    );

    function automatic int getq(input int i);
        case (i)
            0: return int'($signed(q0));
            1: return int'($signed(q1));
            2: return int'($signed(q2));
            default: return int'($signed(q3));
        endcase
    endfunction

    // Reference: exact integer division, then round and clamp.
    function automatic exp_t model(input int a, input int b, input int qw, input int rnd);
        exp_t e;
        longint mag, m, lp, ln;
        bit s;
        s = a < 0;
        mag = s ? -longint'(a) : longint'(a);
        lp = (longint'(1) << (qw - 1)) - 1;
        ln = longint'(1) << (qw - 1);
        e.tag = 0;
        e.dz = (b == 0);
        e.sat = 1'b0;
        if (b == 0) begin
            e.sat = 1'b1;
            e.q = s ? int'(-ln) : int'(lp);
        end else begin
            m = mag / b;
            if (rnd != 0 && 2 * (mag % b) >= b) m = m + 1;
            if (s ? (m > ln) : (m > lp)) begin
                e.sat = 1'b1;
                e.q = s ? int'(-ln) : int'(lp);
            end else begin
                e.q = s ? int'(-m) : int'(m);
            end
        end
        return e;
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic run_vec(input int k, input vec_t v);
        int n;
        int i;
        i = v.inst;
        @(posedge clk); #1;
        dvd = 19'(v.a);
        dvs = 8'(v.b);
        tg = 6'(k);
        iv = '0;
        iv[i] = 1'b1;
        ordy = 1'b1;
        @(posedge clk); #1;
        iv = '0;
        n = 0;
        while (!ovld[i] && n < 30) begin
            @(posedge clk); #1;
            n++;
        end
        chk($sformatf("v%0d latency", k), n, lats[i] - 1);
        chk($sformatf("v%0d quotient", k), getq(i), v.q);
        chk($sformatf("v%0d tag", k), int'(otag[i]), k % 64);
        chk($sformatf("v%0d dz", k), int'(odz[i]), int'(v.dz));
        chk($sformatf("v%0d sat", k), int'(osat[i]), int'(v.sat));
    endtask

    task automatic stream(input logic [3:0] mask, input bit bp);
        exp_t mem [4][64];
        exp_t e;
        int wr [4], rd [4], fa [4], fv [4], lv [4], nout [4];
        bit stall [4];
        int hq [4], ht [4], hs [4];
        int sent, cyc, a, b;
        bit pend;
        sent = 0; cyc = 0; a = 0; b = 0; pend = 1'b0;
        for (int i = 0; i < 4; i++) begin
            wr[i] = 0; rd[i] = 0; fa[i] = -1; fv[i] = -1; lv[i] = -1;
            nout[i] = 0; stall[i] = 1'b0; hq[i] = 0; ht[i] = 0; hs[i] = 0;
        end
        @(posedge clk); #1;
        while ((sent < 32 || pend) && cyc < 600) begin
            if (sent < 32) begin
                if (sent % 3 == 0) a = int'($urandom_range(0, 40000)) - 20000;
                else a = int'($urandom_range(0, 524287)) - 262144;
                b = int'($urandom_range(0, 255));
                if (sent % 8 == 5) b = 0;
                iv = mask;
                dvd = 19'(a);
                dvs = 8'(b);
                tg = 6'(sent);
            end else begin
                iv = '0;
            end
            ordy = bp ? (cyc % 4 == 0 || cyc % 4 == 3) : 1'b1;
            @(negedge clk);
            for (int i = 0; i < 4; i++) begin
                if (mask[i]) begin
                    if (iv[i] && irdy[i]) begin
                        mem[i][wr[i] % 64] = model(a, b, qws[i], rnds[i]);
                        mem[i][wr[i] % 64].tag = sent;
                        wr[i]++;
                        if (fa[i] < 0) fa[i] = cyc;
                    end
                    if (ovld[i]) begin
                        if (fv[i] < 0) fv[i] = cyc;
                        lv[i] = cyc;
                        if (stall[i]) begin
                            chk($sformatf("i%0d hold q", i), getq(i), hq[i]);
                            chk($sformatf("i%0d hold tag", i), int'(otag[i]), ht[i]);
                            chk($sformatf("i%0d hold sat", i), int'(osat[i]), hs[i]);
                        end
                        if (ordy) begin
                            stall[i] = 1'b0;
                            nout[i]++;
                            if (rd[i] == wr[i]) begin
                                chk($sformatf("i%0d unexpected out", i), 1, 0);
                            end else begin
                                e = mem[i][rd[i] % 64];
                                rd[i]++;
                                chk($sformatf("i%0d tag", i), int'(otag[i]), e.tag);
                                chk($sformatf("i%0d q t%0d", i, e.tag), getq(i), e.q);
                                chk($sformatf("i%0d dz t%0d", i, e.tag), int'(odz[i]), int'(e.dz));
                                chk($sformatf("i%0d sat t%0d", i, e.tag), int'(osat[i]), int'(e.sat));
                            end
                        end else begin
                            stall[i] = 1'b1;
                            hq[i] = getq(i);
                            ht[i] = int'(otag[i]);
                            hs[i] = int'(osat[i]);
                        end
                    end else if (stall[i]) begin
                        chk($sformatf("i%0d dropped while stalled", i), 0, 1);
                        stall[i] = 1'b0;
                    end
                end
            end
            if (bp) chk("bp in_ready", int'(irdy[0]), int'(!ovld[0] || ordy));
            if (iv[0] && irdy[0]) sent++;
            pend = 1'b0;
            for (int i = 0; i < 4; i++) if (mask[i] && wr[i] != rd[i]) pend = 1'b1;
            cyc++;
            @(posedge clk); #1;
        end
        iv = '0;
        ordy = 1'b1;
        chk("stream cycle budget", int'(cyc < 600), 1);
        for (int i = 0; i < 4; i++) begin
            if (mask[i]) begin
                chk($sformatf("i%0d result count", i), nout[i], 32);
                if (!bp) begin
                    chk($sformatf("i%0d first latency", i), fv[i] - fa[i], lats[i]);
                    chk($sformatf("i%0d consecutive", i), lv[i] - fv[i], 31);
                end
            end
        end
    endtask

    initial begin
        int n;
        vt[0]  = '{0, 1000, 16, 63, 0, 0};
        vt[1]  = '{0, -1000, 16, -63, 0, 0};
        vt[2]  = '{0, 999, 16, 62, 0, 0};
        vt[3]  = '{1, 1000, 16, 62, 0, 0};
        vt[4]  = '{1, -1000, 16, -62, 0, 0};
        vt[5]  = '{0, 500, 0, 1023, 1, 1};
        vt[6]  = '{0, -5, 0, -1024, 1, 1};
        vt[7]  = '{0, 0, 0, 1023, 1, 1};
        vt[8]  = '{0, 262143, 1, 1023, 0, 1};
        vt[9]  = '{0, -262144, 1, -1024, 0, 1};
        vt[10] = '{0, -1024, 1, -1024, 0, 0};
        vt[11] = '{0, 1024, 1, 1023, 0, 1};
        vt[12] = '{0, 2047, 2, 1023, 0, 1};
        vt[13] = '{0, 0, 5, 0, 0, 0};
        vt[14] = '{2, 127, 1, 127, 0, 0};
        vt[15] = '{2, 128, 1, 127, 0, 1};
        vt[16] = '{2, -128, 1, -128, 0, 0};
        vt[17] = '{2, -129, 1, -128, 0, 1};
        vt[18] = '{2, 500, 0, 127, 1, 1};
        vt[19] = '{3, 262143, 1, 1023, 0, 1};
        vt[20] = '{3, -1024, 1, -1024, 0, 0};
        vt[21] = '{3, 1000, 16, 63, 0, 0};
        vt[22] = '{1, -7, 2, -3, 0, 0};
        vt[23] = '{0, -7, 2, -4, 0, 0};

        #2;
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("reset i%0d valid", i), int'(ovld[i]), 0);
            chk($sformatf("reset i%0d q", i), getq(i), 0);
            chk($sformatf("reset i%0d tag", i), int'(otag[i]), 0);
            chk($sformatf("reset i%0d flags", i), int'({odz[i], osat[i]}), 0);
            chk($sformatf("reset i%0d in_ready", i), int'(irdy[i]), 1);
        end
        @(posedge clk); @(posedge clk); #1;
        rst = 1'b0;

        for (int k = 0; k < NV; k++) run_vec(k, vt[k]);

        stream(4'b1111, 1'b0);
        stream(4'b0001, 1'b1);

        @(posedge clk); #1;
        dvd = 19'(5000);
        dvs = 8'(7);
        tg = 6'd40;
        iv = 4'b0001;
        ordy = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        iv = '0;
        rst = 1'b1;
        #1;
        chk("midrst valid", int'(ovld[0]), 0);
        chk("midrst q", getq(0), 0);
        chk("midrst tag", int'(otag[0]), 0);
        chk("midrst flags", int'({odz[0], osat[0]}), 0);
        chk("midrst in_ready", int'(irdy[0]), 1);
        @(posedge clk); #1;
        rst = 1'b0;
        n = 0;
        repeat (12) begin
            @(negedge clk);
            if (ovld[0]) n++;
        end
        chk("midrst no stale output", n, 0);
        run_vec(99, '{0, 100, 10, 10, 0, 0});

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
